// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a
// 2-credit limit, buffers responses in a 2-entry queue, and flushes stale words on redirect.
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemReady,
    input  logic                  imemValid,
    input  logic [INSN_WIDTH-1:0] imemData,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectPC,
    output logic                  insnValid,
    input  logic                  insnReady,
    output logic [INSN_WIDTH-1:0] insn,
    output logic [ADDR_WIDTH-1:0] insnPC
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(4);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [1:0]            outst_q, outst_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            drop_q, drop_d;
    logic [INSN_WIDTH-1:0] qd_q [2];
    logic [INSN_WIDTH-1:0] qd_d [2];
    logic [ADDR_WIDTH-1:0] qp_q [2];
    logic [ADDR_WIDTH-1:0] qp_d [2];

    logic       pop_s;
    logic       accept_s;
    logic       resp_s;
    logic [2:0] credit_s;
    logic [1:0] fill_s;

    assign insnValid = (cnt_q != 2'd0);
    assign insn      = qd_q[0];
    assign insnPC    = qp_q[0];
    assign imemAddr  = pc_q;

    // A same-cycle pop frees a credit; imemReady never feeds back into the request.
    assign pop_s    = insnValid & insnReady;
    assign credit_s = {1'b0, outst_q} + {1'b0, cnt_q} - {2'b00, pop_s};
    assign imemReq  = ~rst & (state_q == ST_FETCH) & ~redirect & (credit_s < 3'd2);
    assign accept_s = imemReq & imemReady;
    assign resp_s   = imemValid & (outst_q != 2'd0);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        qd_d      = qd_q;
        qp_d      = qp_q;
        fill_s    = cnt_q;
        if (redirect) begin
            // Everything still in flight is stale; a response landing now is one of them.
            pc_d      = redirectPC;
            resp_pc_d = redirectPC;
            cnt_d     = 2'd0;
            outst_d   = outst_q - {1'b0, resp_s};
            drop_d    = outst_q - {1'b0, resp_s};
            state_d   = (drop_d == 2'd0) ? ST_FETCH : ST_FLUSH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (pop_s) begin
                        qd_d[0] = qd_q[1];
                        qp_d[0] = qp_q[1];
                        fill_s  = cnt_q - 2'd1;
                    end else begin
                        fill_s  = cnt_q;
                    end
                    if (resp_s) begin
                        if (fill_s == 2'd0) begin
                            qd_d[0] = imemData;
                            qp_d[0] = resp_pc_q;
                        end else begin
                            qd_d[1] = imemData;
                            qp_d[1] = resp_pc_q;
                        end
                        cnt_d     = fill_s + 2'd1;
                        resp_pc_d = resp_pc_q + PC_INC;
                    end else begin
                        cnt_d     = fill_s;
                    end
                    if (accept_s) begin
                        pc_d = pc_q + PC_INC;
                    end else begin
                        pc_d = pc_q;
                    end
                    outst_d = outst_q + {1'b0, accept_s} - {1'b0, resp_s};
                    state_d = ST_FETCH;
                end
                ST_FLUSH: begin
                    if (resp_s) begin
                        drop_d  = drop_q - 2'd1;
                        outst_d = outst_q - 2'd1;
                    end else begin
                        drop_d  = drop_q;
                        outst_d = outst_q;
                    end
                    state_d = (drop_d == 2'd0) ? ST_FETCH : ST_FLUSH;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State and queue registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= 2'd0;
            cnt_q     <= 2'd0;
            drop_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                qd_q[i] <= '0;
                qp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            for (int i = 0; i < 2; i++) begin
                qd_q[i] <= qd_d[i];
                qp_q[i] <= qp_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency memory model plus a
// pop-order scoreboard, with hand-computed cycle checks per scenario.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        insnValid;
    logic        insnReady;
    logic [31:0] insn;
    logic [31:0] insnPC;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_pop = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] mq_addr [$];
    int          mq_due [$];

    fetch_unit #(
        .ADDR_WIDTH (32),
        .INSN_WIDTH (32),
        .RESET_PC   (RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemValid  (imemValid),
        .imemData   (imemData),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .insnValid  (insnValid),
        .insnReady  (insnReady),
        .insn       (insn),
        .insnPC     (insnPC)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called just after a rising edge: present this cycle's memory response.
    task automatic settle();
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imemValid = 1'b1;
            imemData  = mem_word(mq_addr[0]);
        end else begin
            imemValid = 1'b0;
            imemData  = 32'h0;
        end
        #1;
    endtask

    // Bookkeeping at the falling edge, then move to just after the next rising edge.
    task automatic advance();
        @(negedge clk);
        if (imemValid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (!rst && imemReq && imemReady) begin
            mq_addr.push_back(imemAddr);
            mq_due.push_back(cyc + lat);
        end
        if (!rst && insnValid && insnReady) begin
            check_eq("pop_pc", insnPC, exp_pc);
            check_eq("pop_insn", insn, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (!rst && redirect) exp_pc = redirectPC;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            exp_pc = RPC;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        step();
        step();
        rst   = 1'b0;
        n_pop = 0;
    endtask

    initial begin
        rst        = 1'b1;
        imemReady  = 1'b1;
        imemValid  = 1'b0;
        imemData   = 32'h0;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        insnReady  = 1'b1;
        @(posedge clk);
        #1;

        // Reset values, then streaming with 1-cycle memory
        lat = 1;
        step();
        step();
        settle();
        check_eq("rst_req", 32'(imemReq), 32'd0);
        check_eq("rst_valid", 32'(insnValid), 32'd0);
        check_eq("rst_insn", insn, 32'h0);
        check_eq("rst_insnpc", insnPC, 32'h0);
        check_eq("rst_addr", imemAddr, RPC);
        advance();
        rst   = 1'b0;
        n_pop = 0;
        settle();
        check_eq("c0_req", 32'(imemReq), 32'd1);
        check_eq("c0_addr", imemAddr, 32'h100);
        advance();
        settle();
        check_eq("c1_addr", imemAddr, 32'h104);
        check_eq("c1_valid", 32'(insnValid), 32'd0);
        advance();
        settle();
        check_eq("c2_addr", imemAddr, 32'h108);
        check_eq("c2_valid", 32'(insnValid), 32'd1);
        check_eq("c2_insnpc", insnPC, 32'h100);
        advance();
        repeat (5) step();
        check_eq("tput_pops", 32'(n_pop), 32'd6);

        // Backpressure: decode stalls 6 cycles
        insnReady = 1'b0;
        apply_reset();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("bp_req", 32'(imemReq), 32'd0);
            check_eq("bp_valid", 32'(insnValid), 32'd1);
            check_eq("bp_head", insnPC, 32'h100);
            advance();
        end
        insnReady = 1'b1;
        repeat (6) step();
        check_eq("bp_pops", 32'(n_pop), 32'd6);

        // Memory stall: imemReady low 4 cycles
        apply_reset();
        imemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("stall_req", 32'(imemReq), 32'd1);
            check_eq("stall_addr", imemAddr, 32'h100);
            advance();
        end
        imemReady = 1'b1;
        settle();
        check_eq("unstall_addr", imemAddr, 32'h100);
        advance();
        settle();
        check_eq("after_stall_addr", imemAddr, 32'h104);
        advance();
        repeat (3) step();
        check_eq("stall_pops", 32'(n_pop), 32'd3);

        // Redirect with two stale responses in flight (3-cycle memory)
        lat = 3;
        apply_reset();
        step();
        settle();
        check_eq("rd_c1_addr", imemAddr, 32'h104);
        advance();
        redirect   = 1'b1;
        redirectPC = 32'h400;
        settle();
        check_eq("rd_c2_req", 32'(imemReq), 32'd0);
        advance();
        redirect = 1'b0;
        settle();
        check_eq("flush1_valid", 32'(insnValid), 32'd0);
        check_eq("flush1_req", 32'(imemReq), 32'd0);
        advance();
        settle();
        check_eq("flush2_valid", 32'(insnValid), 32'd0);
        check_eq("flush2_req", 32'(imemReq), 32'd0);
        advance();
        settle();
        check_eq("rd_first_req", 32'(imemReq), 32'd1);
        check_eq("rd_first_addr", imemAddr, 32'h400);
        advance();
        repeat (3) step();
        settle();
        check_eq("rd_valid", 32'(insnValid), 32'd1);
        check_eq("rd_insnpc", insnPC, 32'h400);
        advance();

        // Redirect coinciding with a response and a pop
        lat = 1;
        apply_reset();
        step();
        step();
        redirect   = 1'b1;
        redirectPC = 32'h800;
        settle();
        check_eq("sim_valid", 32'(insnValid), 32'd1);
        check_eq("sim_req", 32'(imemReq), 32'd0);
        advance();
        redirect = 1'b0;
        settle();
        check_eq("sim_next_valid", 32'(insnValid), 32'd0);
        check_eq("sim_next_addr", imemAddr, 32'h800);
        check_eq("sim_next_req", 32'(imemReq), 32'd1);
        advance();
        repeat (3) step();
        check_eq("sim_pops", 32'(n_pop), 32'd3);

        // Second redirect while flushing: latest target wins
        lat = 3;
        apply_reset();
        step();
        step();
        redirect   = 1'b1;
        redirectPC = 32'h400;
        step();
        redirectPC = 32'h600;
        settle();
        check_eq("rr_req", 32'(imemReq), 32'd0);
        advance();
        redirect = 1'b0;
        settle();
        check_eq("rr_flush_req", 32'(imemReq), 32'd0);
        advance();
        settle();
        check_eq("rr_req_addr", imemAddr, 32'h600);
        check_eq("rr_req_on", 32'(imemReq), 32'd1);
        advance();
        repeat (3) step();
        settle();
        check_eq("rr_insnpc", insnPC, 32'h600);
        check_eq("rr_valid", 32'(insnValid), 32'd1);
        advance();

        // Reset while flushing, with redirect also asserted
        apply_reset();
        step();
        step();
        redirect   = 1'b1;
        redirectPC = 32'h400;
        step();
        rst        = 1'b1;
        redirectPC = 32'h700;
        settle();
        check_eq("rf_req", 32'(imemReq), 32'd0);
        advance();
        rst      = 1'b0;
        redirect = 1'b0;
        lat      = 1;
        settle();
        check_eq("rf_addr", imemAddr, RPC);
        check_eq("rf_req_on", 32'(imemReq), 32'd1);
        check_eq("rf_valid", 32'(insnValid), 32'd0);
        advance();
        step();
        settle();
        check_eq("rf_insn_valid", 32'(insnValid), 32'd1);
        check_eq("rf_insnpc", insnPC, RPC);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
